alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_shifter.sv | 56 +++++
 rtl/alu_exec_unit.sv | 140 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, FSM states and decode helpers.
// Used by the execution unit, its shifter and the ALU controller.
package alu_pkg;

    localparam int XLEN = 32;
    localparam int SHW  = 5;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_SUB = 5'd1,
        ALU_AND = 5'd2,
        ALU_OR  = 5'd3,
        ALU_XOR = 5'd4,
        ALU_NOR = 5'd5,
        ALU_SLL = 5'd6,
        ALU_SRL = 5'd7,
        ALU_SRA = 5'd8,
        ALU_SLT = 5'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift(input logic [4:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Iterative one-bit-per-cycle shifter with captured direction and fill bit.
// next_o exposes the value the data register takes on the coming edge.
module alu_shifter
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  alu_op_e         op_i,
    input  logic [SHW-1:0]  amt_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] next_o,
    output logic            last_o
);

    logic [XLEN-1:0] data_q, data_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            left_q, left_d;
    logic            fill_q, fill_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        left_d = left_q;
        fill_d = fill_q;
        if (load_i) begin
            data_d = data_i;
            cnt_d  = amt_i;
            left_d = (op_i == ALU_SLL);
            fill_d = (op_i == ALU_SRA) & data_i[XLEN-1];
        end else if (cnt_q != '0) begin
            data_d = left_q ? {data_q[XLEN-2:0], 1'b0}
                            : {fill_q, data_q[XLEN-1:1]};
            cnt_d  = cnt_q - 5'd1;
        end
    end

    // The step that takes the count to zero is the final one.
    assign last_o = (cnt_q == 5'd1) & ~load_i;
    assign next_o = data_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
            cnt_q  <= '0;
            left_q <= 1'b0;
            fill_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            left_q <= left_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: valid/ready handshake, single-cycle arithmetic/logic
// and compare, and multi-cycle shifts delegated to alu_shifter.
module alu_exec_unit
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      ALUCtrl,
    input  logic            Sign,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            overflow,
    output logic            illegal
);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            ovf_q, ovf_d;
    logic            ill_q, ill_d;

    alu_op_e         op;
    logic [XLEN-1:0] sum, diff;
    logic            lt;
    logic [XLEN-1:0] alu_res;
    logic            alu_ovf;
    logic            alu_ill;

    logic            sh_load;
    logic            sh_last;
    logic [XLEN-1:0] sh_next;

    assign op   = alu_op_e'(ALUCtrl);
    assign sum  = in1 + in2;
    assign diff = in1 - in2;
    assign lt   = Sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (op)
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = Sign & (in1[31] == in2[31]) & (sum[31] != in1[31]);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = Sign & (in1[31] != in2[31]) & (diff[31] != in1[31]);
            end
            ALU_AND: alu_res = in1 & in2;
            ALU_OR:  alu_res = in1 | in2;
            ALU_XOR: alu_res = in1 ^ in2;
            ALU_NOR: alu_res = ~(in1 | in2);
            // Zero-amount shifts complete immediately with the operand.
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = in2;
            ALU_SLT: alu_res = {31'd0, lt};
            default: alu_ill = 1'b1;
        endcase
    end

    alu_shifter u_shifter (
        .clk    (clk),
        .reset  (reset),
        .load_i (sh_load),
        .op_i   (op),
        .amt_i  (in1[SHW-1:0]),
        .data_i (in2),
        .next_o (sh_next),
        .last_o (sh_last)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        sh_load  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    ovf_d = alu_ovf;
                    ill_d = alu_ill;
                    if (is_shift(ALUCtrl) && (in1[SHW-1:0] != '0)) begin
                        sh_load = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (sh_last) begin
                    result_d = sh_next;
                    zero_d   = (sh_next == '0);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, handshake/reset
// sequences and randomized ops against an arithmetic reference model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  ALUCtrl;
    logic        Sign;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        v;
        logic        il;
        int          lat;
    } exp_t;

    typedef struct {
        logic [4:0]  op;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
    } vec_t;

    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -MAXI - 64'sd1;

    alu_exec_unit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUCtrl   (ALUCtrl),
        .Sign      (Sign),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [4:0] op, input logic sg,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        longint sa, sb, s;
        logic signed [31:0] bs;
        int k;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        bs = b;
        k = int'(a[4:0]);
        e.r = '0;
        e.v = 1'b0;
        e.il = 1'b0;
        e.lat = 1;
        case (op)
            5'd0: begin
                s = sa + sb;
                e.r = a + b;
                e.v = sg && (s > MAXI || s < MINI);
            end
            5'd1: begin
                s = sa - sb;
                e.r = a - b;
                e.v = sg && (s > MAXI || s < MINI);
            end
            5'd2: e.r = a & b;
            5'd3: e.r = a | b;
            5'd4: e.r = a ^ b;
            5'd5: e.r = ~(a | b);
            5'd6: begin e.r = b << k; e.lat = k + 1; end
            5'd7: begin e.r = b >> k; e.lat = k + 1; end
            5'd8: begin e.r = bs >>> k; e.lat = k + 1; end
            5'd9: e.r = (sg ? (sa < sb) : (a < b)) ? 32'd1 : 32'd0;
            default: e.il = 1'b1;
        endcase
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    // Issues one op from IDLE, waits for out_valid, then consumes it.
    task automatic do_op(input logic [4:0] op, input logic sg,
                         input logic [31:0] a, input logic [31:0] b,
                         output exp_t g);
        ALUCtrl = op;
        Sign = sg;
        in1 = a;
        in2 = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in1 = $urandom;
        in2 = $urandom;
        ALUCtrl = 5'($urandom);
        Sign = 1'($urandom);
        g.lat = 1;
        while (!out_valid && g.lat <= 40) begin
            @(posedge clk);
            #1;
            g.lat++;
        end
        if (!out_valid) g.lat = -1;
        g.r = result;
        g.z = zero;
        g.v = overflow;
        g.il = illegal;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic cmp(input string tag, input exp_t g, input exp_t e);
        chk({tag, ".result"}, g.r, e.r);
        chk({tag, ".zero"}, 32'(g.z), 32'(e.z));
        chk({tag, ".overflow"}, 32'(g.v), 32'(e.v));
        chk({tag, ".illegal"}, 32'(g.il), 32'(e.il));
        chk({tag, ".latency"}, 32'(g.lat), 32'(e.lat));
    endtask

    function automatic vec_t mk(input logic [4:0] op, input logic sg,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] r, input logic z,
                                input logic v, input logic il,
                                input int lat);
        vec_t t;
        t.op = op; t.sg = sg; t.a = a; t.b = b;
        t.e.r = r; t.e.z = z; t.e.v = v; t.e.il = il; t.e.lat = lat;
        return t;
    endfunction

    vec_t vecs[16];

    initial begin
        exp_t g;
        exp_t e;
        logic saw;
        logic [4:0] op;

        vecs[0]  = mk(5'd0, 1, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 1, 0, 1);
        vecs[1]  = mk(5'd0, 0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 0, 1);
        vecs[2]  = mk(5'd8, 0, 32'd4, 32'hF0000000, 32'hFF000000, 0, 0, 0, 5);
        vecs[3]  = mk(5'd7, 0, 32'd4, 32'hF0000000, 32'h0F000000, 0, 0, 0, 5);
        vecs[4]  = mk(5'd9, 1, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0, 0, 1);
        vecs[5]  = mk(5'd9, 0, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 0, 0, 1);
        vecs[6]  = mk(5'h1F, 1, 32'h1234, 32'h5678, 32'h0, 1, 0, 1, 1);
        vecs[7]  = mk(5'd6, 0, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0, 1);
        vecs[8]  = mk(5'd1, 1, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 1, 0, 1);
        vecs[9]  = mk(5'd2, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 1);
        vecs[10] = mk(5'd3, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0, 1);
        vecs[11] = mk(5'd4, 1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0, 1);
        vecs[12] = mk(5'd5, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, 0, 1);
        vecs[13] = mk(5'd6, 1, 32'h3F, 32'h1, 32'h80000000, 0, 0, 0, 32);
        vecs[14] = mk(5'd1, 0, 32'h0, 32'h1, 32'hFFFFFFFF, 0, 0, 0, 1);
        vecs[15] = mk(5'd0, 1, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 0, 0, 1);

        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        ALUCtrl = '0;
        Sign = 1'b0;
        in1 = '0;
        in2 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.zero", 32'(zero), 32'd0);
        chk("rst.overflow", 32'(overflow), 32'd0);
        chk("rst.illegal", 32'(illegal), 32'd0);

        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].op, vecs[i].sg, vecs[i].a, vecs[i].b, g);
            cmp($sformatf("vec%0d", i), g, vecs[i].e);
        end

        // Stall in DONE with a new request pending; it must wait.
        ALUCtrl = 5'd1;
        Sign = 1'b0;
        in1 = 32'h12345678;
        in2 = 32'h12345678;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        ALUCtrl = 5'd0;
        in1 = 32'd1;
        in2 = 32'd1;
        for (int i = 0; i < 3; i++) begin
            chk("hold.out_valid", 32'(out_valid), 32'd1);
            chk("hold.in_ready", 32'(in_ready), 32'd0);
            chk("hold.result", result, 32'd0);
            chk("hold.zero", 32'(zero), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("leave.out_valid", 32'(out_valid), 32'd0);
        chk("leave.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("next.out_valid", 32'(out_valid), 32'd1);
        chk("next.result", result, 32'd2);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of a long shift aborts it.
        ALUCtrl = 5'd6;
        in1 = 32'd31;
        in2 = 32'd1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (out_valid) saw = 1'b1;
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        out_ready = 1'b0;
        chk("abort.in_ready", 32'(in_ready), 32'd1);
        chk("abort.out_valid", 32'(out_valid), 32'd0);
        chk("abort.result", result, 32'd0);
        chk("abort.zero", 32'(zero), 32'd0);
        chk("abort.overflow", 32'(overflow), 32'd0);
        chk("abort.illegal", 32'(illegal), 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (out_valid) saw = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("abort.never_valid", 32'(saw), 32'd0);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        sg;
            op = 5'($urandom_range(0, 10));
            if (op == 5'd10) op = 5'($urandom_range(10, 31));
            a = $urandom;
            b = $urandom;
            sg = 1'($urandom);
            if ($urandom_range(0, 3) == 0) a = b;
            if ($urandom_range(0, 3) == 0) a = {1'b0, a[30:0]};
            e = model(op, sg, a, b);
            do_op(op, sg, a, b, g);
            cmp($sformatf("rnd%0d_op%0d", n, op), g, e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
